int_regfile_wr_port: RTL

Responder side of the register-file write handshake (`rf_wr_req`/`rf_wr_sel`/`rf_wr_data`/`rf_wr_ack`) used by multi-cycle units such as the integer divider. The block owns the integer register file storage. It arbitrates round-robin between `num_clients` handshaking writers, gives absolute priority to a single-cycle core write-back port, and provides two combinational read ports. x0 is hardwired to zero.

---
 rtl/int_regfile_pkg.sv | 13 +
 rtl/int_regfile_wr_port_rr_arbiter.sv | 43 ++++
 rtl/int_regfile_wr_port.sv | 95 +++++++++
 3 files changed

// File: rtl/int_regfile_pkg.sv
// Integer register file shared types and default geometry,
// common to the write port and its multi-cycle clients.
package int_regfile_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int NUM_REGS    = 32;
    localparam int NUM_CLIENTS = 2;
    localparam int SEL_WIDTH   = $clog2(NUM_REGS);

    typedef logic [SEL_WIDTH-1:0]  reg_sel_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/int_regfile_wr_port_rr_arbiter.sv
// Round-robin arbiter; search starts one past the last grant,
// which only advances when enabled and something was granted.
module rr_arbiter #(
    parameter int n  = 2,
    parameter int iw = (n > 1) ? $clog2(n) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [n-1:0]  req,
    input  logic          enable,
    output logic [n-1:0]  grant,
    output logic [iw-1:0] grant_idx
);

    typedef logic [iw-1:0] idx_t;

    idx_t last_grant;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (!found && req[(int'(last_grant) + k) % n]) begin
                found     = 1'b1;
                grant_idx = idx_t'((int'(last_grant) + k) % n);
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= idx_t'(n - 1);
        end else if (enable && found) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/int_regfile_wr_port.sv
// Integer register file with a priority core write-back port,
// round-robin handshaking writers and two combinational reads.
module int_regfile_wr_port
    import int_regfile_pkg::*;
#(
    parameter int data_width    = DATA_WIDTH,
    parameter int num_regs      = NUM_REGS,
    parameter int num_clients   = NUM_CLIENTS,
    parameter int reg_sel_width = $clog2(num_regs)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 core_wr_en,
    input  logic [reg_sel_width-1:0]             core_wr_sel,
    input  logic [data_width-1:0]                core_wr_data,
    input  logic [num_clients-1:0]               rf_wr_req,
    input  logic [num_clients*reg_sel_width-1:0] rf_wr_sel,
    input  logic [num_clients*data_width-1:0]    rf_wr_data,
    output logic [num_clients-1:0]               rf_wr_ack,
    input  logic [reg_sel_width-1:0]             rd_sel_a,
    input  logic [reg_sel_width-1:0]             rd_sel_b,
    output logic [data_width-1:0]                rd_data_a,
    output logic [data_width-1:0]                rd_data_b
);

    localparam int iw = (num_clients > 1) ? $clog2(num_clients) : 1;

    logic [num_clients-1:0]   eligible;
    logic [num_clients-1:0]   grant;
    logic [num_clients-1:0]   grant_eff;
    logic [iw-1:0]            grant_idx;
    logic                     wr_en;
    logic [reg_sel_width-1:0] wr_sel;
    logic [data_width-1:0]    wr_data;
    logic [data_width-1:0]    regs [num_regs];

    // A client still seeing its ack is presenting the write just served.
    assign eligible = rf_wr_req & ~rf_wr_ack;

    rr_arbiter #(
        .n (num_clients)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (eligible),
        .enable    (~core_wr_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_eff = core_wr_en ? '0 : grant;

    always_comb begin
        wr_en   = 1'b0;
        wr_sel  = '0;
        wr_data = '0;
        if (core_wr_en) begin
            wr_en   = 1'b1;
            wr_sel  = core_wr_sel;
            wr_data = core_wr_data;
        end else if (|grant) begin
            wr_en   = 1'b1;
            wr_sel  = rf_wr_sel[int'(grant_idx)*reg_sel_width +: reg_sel_width];
            wr_data = rf_wr_data[int'(grant_idx)*data_width +: data_width];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wr_ack <= '0;
        end else begin
            rf_wr_ack <= grant_eff;
        end
    end

    // Entry 0 is cleared by reset and never written, so it reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < num_regs; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_sel != '0)) begin
            regs[wr_sel] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_sel_a];
    assign rd_data_b = regs[rd_sel_b];

    assert_known: assert property (
        @(posedge clk) disable iff (rst)
        !$isunknown({rf_wr_req, core_wr_en})
    );

endmodule
